// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: data-bus responder that queues stored bytes in a small FIFO and
// shifts them out as 8N1 frames; STATUS exposes FIFO and transmitter state.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h1002_0000,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        tx
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

    tx_state_e         r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic              w_sel_data;
    logic              w_sel_status;
    logic              w_full;
    logic              w_empty;
    logic              w_busy;
    logic              w_push_req;
    logic              w_push;
    logic              w_pop;
    logic              w_clr_ovf;
    logic              w_baud_done;
    logic [7:0]        w_head;
    logic [3:0]        w_count_field;
    logic [31:0]       w_status;
    logic              w_unused;

    // Bus decode: Address[2] picks the register, the low two bits are don't-care.
    assign Hit          = (Address[31:3] == BASE_ADDR[31:3]);
    assign w_sel_data   = Hit & ~Address[2];
    assign w_sel_status = Hit &  Address[2];

    assign w_full       = (r_count == DEPTH_C);
    assign w_empty      = (r_count == '0);
    assign w_busy       = (r_state != S_IDLE);
    assign w_baud_done  = (r_baud == BAUD_LAST);

    assign w_push_req   = MemWrite & w_sel_data;
    assign w_push       = w_push_req & ~w_full;
    assign w_clr_ovf    = MemWrite & w_sel_status & WriteData[3];
    assign w_pop        = ~w_empty & ((r_state == S_IDLE) |
                                      ((r_state == S_STOP) & w_baud_done));
    assign w_head       = r_mem[r_rd_ptr];

    generate
        if (CNT_W >= 4) begin : g_cnt_wide
            assign w_count_field = r_count[3:0];
        end else begin : g_cnt_narrow
            assign w_count_field = {{(4 - CNT_W){1'b0}}, r_count};
        end
    endgenerate

    assign w_status = {24'h0, w_count_field, r_overflow, w_busy, w_empty, w_full};

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        ReadData = 32'h0;
        if (MemRead && w_sel_status) begin
            ReadData = w_status;
        end
    end

    assign w_unused = &{1'b0, Address[1:0], WriteData[31:8]};

    // NOTE: FIFO storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= WriteData[7:0];
        end
    end

    // A push into a full FIFO is dropped even if the FSM pops in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_done) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        // Chain straight into the next start bit when data is waiting.
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_baud  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed stimulus with expected frames and load results queued
// up front; independent monitors decode the serial line and the bus reads.
module tb_mmio_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] BASE  = 32'h1002_0000;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        hit;
    } rd_t;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        MemWrite  = 1'b0;
    logic        MemRead   = 1'b0;
    logic [31:0] Address   = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic        Hit;
    logic        tx;

    frame_t exp_frames [$];
    rd_t    exp_reads  [$];
    int     n_cmp     = 0;
    int     n_bad     = 0;
    int     cyc       = 0;
    int     last_edge = 0;
    bit     rx_abort  = 1'b0;

    mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .Address  (Address),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .Hit      (Hit),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWrite  = we;
        MemRead   = re;
        Address   = a;
        WriteData = d;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, a, d);
        last_edge = cyc + 1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic hit);
        rd_t e;
        drive(1'b0, 1'b1, a, 32'h0);
        e.addr = a;
        e.data = exp;
        e.hit  = hit;
        exp_reads.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic expect_frame(input logic [7:0] data, input int start);
        frame_t f;
        f.data  = data;
        f.start = start;
        exp_frames.push_back(f);
    endtask

    task automatic rx_wait(input int n);
        repeat (n) begin
            @(negedge clk);
            if (reset) rx_abort = 1'b1;
        end
    endtask

    // Bus monitor: loads are compared in the cycle they are issued, away from the edge.
    initial begin
        rd_t e;
        forever begin
            @(negedge clk);
            #1;
            if (MemRead) begin
                if (exp_reads.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_read: got 0x%08h expected no load (cycle %0d)", ReadData, cyc);
                end else begin
                    e = exp_reads.pop_front();
                    check($sformatf("ReadData@%08h", e.addr), ReadData, e.data);
                    check($sformatf("Hit@%08h", e.addr), {31'h0, Hit}, {31'h0, e.hit});
                end
            end else if (Hit) begin
                check("ReadData_no_load", ReadData, 32'h0);
            end
        end
    end

    // Serial monitor: samples each bit at its centre; a reset aborts the frame.
    initial begin
        frame_t     e;
        logic [7:0] rx;
        logic       stop_bit;
        int         start_cyc;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                start_cyc = cyc;
                rx_abort  = 1'b0;
                rx        = 8'h0;
                rx_wait(2);
                if (!rx_abort) check("start_bit", {31'h0, tx}, 32'h0);
                for (int k = 0; k < 8; k++) begin
                    rx_wait(CPB);
                    rx[k] = tx;
                end
                rx_wait(CPB);
                stop_bit = tx;
                rx_wait(1);
                if (!rx_abort) begin
                    if (exp_frames.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_frame: got byte 0x%02h expected no frame (start cycle %0d)", rx, start_cyc);
                    end else begin
                        e = exp_frames.pop_front();
                        check("frame_data", {24'h0, rx}, {24'h0, e.data});
                        check("frame_start_cycle", start_cyc, e.start);
                        check("stop_bit", {31'h0, stop_bit}, 32'h1);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] burst [5];
        logic [7:0] fill  [5];
        int         s;
        burst = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A};
        fill  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("tx_after_reset", {31'h0, tx}, 32'h1);
        rd(BASE + 32'd4, 32'h2, 1'b1);
        idle(2);

        // Single frame 0xA5: STATUS traced every cycle pins busy to exactly one frame
        wr(BASE, 32'hA5);
        s = last_edge;
        expect_frame(8'hA5, s + 1);
        rd(BASE + 32'd4, 32'h10, 1'b1);
        repeat (FRAME) rd(BASE + 32'd4, 32'h06, 1'b1);
        rd(BASE + 32'd4, 32'h02, 1'b1);
        idle(3);

        // Five consecutive stores into a 4-deep FIFO: first pops at once, none dropped
        for (int i = 0; i < 5; i++) begin
            wr(BASE, {24'h0, burst[i]});
            if (i == 0) s = last_edge;
            expect_frame(burst[i], s + 1 + i * FRAME);
        end
        rd(BASE + 32'd4, 32'h45, 1'b1);
        idle(5 * FRAME + 5);
        rd(BASE + 32'd4, 32'h02, 1'b1);

        // Fill with a frame in flight: fifth store is dropped and overflow sticks
        wr(BASE, 32'hC0);
        s = last_edge;
        expect_frame(8'hC0, s + 1);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            wr(BASE, {24'h0, fill[i]});
            if (i < 4) expect_frame(fill[i], s + 1 + (i + 1) * FRAME);
        end
        rd(BASE + 32'd4, 32'h4D, 1'b1);
        wr(BASE + 32'd4, 32'hFFFF_FFF7);
        rd(BASE + 32'd4, 32'h4D, 1'b1);
        wr(BASE + 32'd4, 32'h8);
        rd(BASE + 32'd4, 32'h45, 1'b1);
        idle(5 * FRAME + 5);
        rd(BASE + 32'd4, 32'h02, 1'b1);

        // Reset 13 cycles into a frame (0xC3 bit 2 is low there)
        wr(BASE, 32'hC3);
        s = last_edge;
        expect_frame(8'hC3, s + 1);
        wr(BASE, 32'h99);
        expect_frame(8'h99, s + 1 + FRAME);
        while (cyc < s + 13) idle(1);
        check("tx_mid_frame", {31'h0, tx}, 32'h0);
        #2 reset = 1'b1;
        #1 check("tx_async_reset", {31'h0, tx}, 32'h1);
        exp_frames.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd(BASE + 32'd4, 32'h02, 1'b1);
        idle(FRAME + 20);
        rd(BASE + 32'd4, 32'h02, 1'b1);

        // Accesses just outside the window, plus a TXDATA load
        wr(BASE + 32'd8, 32'h77);
        wr(BASE - 32'd4, 32'h77);
        rd(BASE + 32'd8, 32'h0, 1'b0);
        rd(BASE - 32'd4, 32'h0, 1'b0);
        rd(BASE, 32'h0, 1'b1);
        rd(BASE + 32'd4, 32'h02, 1'b1);
        idle(FRAME + 20);
        check("tx_idle_after_miss", {31'h0, tx}, 32'h1);

        idle(5);
        check("frames_outstanding", exp_frames.size(), 32'h0);
        check("reads_outstanding", exp_reads.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
